// File: rtl/mux_rr_arbiter_if.sv
// Bundle between the four requesters and the round-robin mux arbiter.
// The slave modport is the arbiter side and the master modport is the requester side.
interface mux_rr_arbiter_if;
  logic [3:0] request;
  logic [3:0] grant;
  logic [1:0] selection;
  logic       grantValid;
  logic       switchPulse;

  modport master (
    output request,
    input  grant,
    input  selection,
    input  grantValid,
    input  switchPulse
  );

  modport slave (
    input  request,
    output grant,
    output selection,
    output grantValid,
    output switchPulse
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that drives the select code of a shared 4:1 mux.
// Define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles while others wait.
module mux_rr_arbiter #(
  parameter int MAX_HOLD  = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_WIDTH) - 1) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must lie in 1..2**CNT_WIDTH-1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] last_owner;

  // Returns {found, index}; the bit just after `last` has the highest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] result;
    logic [1:0] idx;
    result = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

  logic [3:0] owner_mask;
  logic [3:0] others;
  logic       owner_req;
  logic [2:0] pick_idle;
  logic [2:0] pick_hand;
  logic       timeout;
  logic       take;
  logic [1:0] take_idx;
  logic       go_idle;

  // In GRANT, last_owner is the current owner.
  assign owner_mask = 4'(1) << last_owner;
  assign others     = bus.request & ~owner_mask;
  assign owner_req  = |(bus.request & owner_mask);
  assign pick_idle  = rr_pick(bus.request, last_owner);
  assign pick_hand  = rr_pick(others, last_owner);

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] HOLD_LIMIT = CNT_WIDTH'(MAX_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_SAT   = '1;

  logic [CNT_WIDTH-1:0] hold_count;

  assign timeout = (state == GRANT) && (hold_count == HOLD_LIMIT) && (|others);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    take     = 1'b0;
    take_idx = pick_idle[1:0];
    go_idle  = 1'b0;
    case (state)
      IDLE:  take = pick_idle[2];
      GRANT: begin
        if (!owner_req || timeout) begin
          take     = pick_hand[2];
          take_idx = pick_hand[1:0];
          go_idle  = !pick_hand[2];
        end
      end
      default: ;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_owner      <= 2'd3;
      bus.grant       <= '0;
      bus.selection   <= 2'b00;
      bus.grantValid  <= 1'b0;
      bus.switchPulse <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_count      <= '0;
`endif
    end else begin
      bus.switchPulse <= take;
      if (take) begin
        state          <= GRANT;
        last_owner     <= take_idx;
        bus.grant      <= 4'(1) << take_idx;
        bus.selection  <= take_idx;
        bus.grantValid <= 1'b1;
      end else if (go_idle) begin
        state          <= IDLE;
        bus.grant      <= '0;
        bus.grantValid <= 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      // A timeout with nobody waiting restarts the hold window for the same owner.
      if (take) begin
        hold_count <= '0;
      end else if (state == GRANT) begin
        if (hold_count == HOLD_LIMIT)      hold_count <= '0;
        else if (hold_count != HOLD_SAT)   hold_count <= hold_count + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomised and directed bench for mux_rr_arbiter against an integer-level model.
// Follows ARB_TIMEOUT_EN the same way the design does.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner index or -1 when idle, last owner, hold cycles, select, pulse.
  int m_owner;
  int m_last;
  int m_hold;
  int m_sel;
  bit m_sw;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_scan(input logic [3:0] req, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (req[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_hold  = 0;
    m_sw    = 1'b1;
  endtask

  task automatic model_update(input logic [3:0] req, input logic r);
    int  win;
    bit  waiting;
    bit  expired;
    if (r) begin
      m_owner = -1; m_last = 3; m_hold = 0; m_sel = 0; m_sw = 1'b0;
      return;
    end
    m_sw = 1'b0;
    if (m_owner < 0) begin
      win = rr_scan(req, m_last, -1);
      if (win >= 0) model_grant(win);
    end else begin
      waiting = rr_scan(req, m_last, m_owner) >= 0;
      expired = TIMEOUT_EN && (m_hold == MAX_HOLD - 1);
      if (!req[m_owner] || (expired && waiting)) begin
        win = rr_scan(req, m_last, m_owner);
        if (win >= 0) model_grant(win);
        else m_owner = -1;
      end else if (expired) begin
        m_hold = 0;
      end else if (m_hold < 15) begin
        m_hold++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] exp_grant;
    exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    check({tag, ".grant"},       32'(bus.grant),       32'(exp_grant));
    check({tag, ".selection"},   32'(bus.selection),   32'(m_sel));
    check({tag, ".grantValid"},  32'(bus.grantValid),  32'(m_owner >= 0));
    check({tag, ".switchPulse"}, 32'(bus.switchPulse), 32'(m_sw));
  endtask

  task automatic step(input string tag, input logic [3:0] req, input logic r);
    bus.request = req;
    rst         = r;
    @(posedge clk);
    model_update(req, r);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [3:0] req;
    bus.request = 4'h0;
    rst         = 1'b1;
    m_owner = -1; m_last = 3; m_hold = 0; m_sel = 0; m_sw = 1'b0;

    // Reset held with every requester active.
    step("reset0", 4'hF, 1'b1);
    step("reset1", 4'hF, 1'b1);
    check("reset.grant_const", 32'(bus.grant), 32'h0);

    // Single requester, then release.
    step("single.grant", 4'b0100, 1'b0);
    check("single.grant_const", 32'(bus.grant), 32'h4);
    check("single.sel_const",   32'(bus.selection), 32'd2);
    check("single.pulse_const", 32'(bus.switchPulse), 32'd1);
    step("single.hold", 4'b0100, 1'b0);
    step("single.drop", 4'b0000, 1'b0);
    check("single.sel_kept", 32'(bus.selection), 32'd2);

    // Fairness: everyone requests, each owner releases after three cycles.
    step("rr.reset", 4'hF, 1'b1);
    step("rr.first", 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("rr.order", 32'(bus.grant), 32'(1 << (i % 4)));
      check("rr.no_bubble", 32'(bus.grantValid), 32'd1);
      step("rr.hold", 4'hF, 1'b0);
      step("rr.hold", 4'hF, 1'b0);
      req = 4'hF & ~4'(1 << (i % 4));
      step("rr.release", req, 1'b0);
    end

    // Direct hand-off from owner 1 to waiting requester 3.
    step("handoff.reset", 4'h0, 1'b1);
    step("handoff.own1", 4'b0010, 1'b0);
    step("handoff.wait", 4'b1010, 1'b0);
    step("handoff.drop", 4'b1000, 1'b0);
    check("handoff.grant_const", 32'(bus.grant), 32'h8);
    check("handoff.sel_const",   32'(bus.selection), 32'd3);
    check("handoff.valid_const", 32'(bus.grantValid), 32'd1);

    // Two persistent requesters: alternation with timeout, fixed owner without.
    step("timeout.reset", 4'h0, 1'b1);
    step("timeout.first", 4'b0011, 1'b0);
    for (int i = 0; i < 8; i++) step("timeout.run", 4'b0011, 1'b0);
    check("timeout.after8", 32'(bus.grant), TIMEOUT_EN ? 32'h2 : 32'h1);
    for (int i = 0; i < 8; i++) step("timeout.run", 4'b0011, 1'b0);
    check("timeout.after16", 32'(bus.grant), 32'h1);
    for (int i = 0; i < 24; i++) step("timeout.run", 4'b0011, 1'b0);

    // Reset while owner 2 holds the mux.
    step("midrst.own2", 4'b0100, 1'b0);
    step("midrst.own2", 4'b0100, 1'b0);
    step("midrst.rst", 4'b0100, 1'b1);
    check("midrst.grant_const", 32'(bus.grant), 32'h0);
    check("midrst.sel_const",   32'(bus.selection), 32'd0);
    step("midrst.regrant", 4'b0100, 1'b0);
    check("midrst.regrant_const", 32'(bus.grant), 32'h4);

    // Random traffic: sticky requests with occasional toggles and rare resets.
    req = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      step("random", req, ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
